spr_file: RTL and testbench
===========================

# spr_file

Parametrised special-purpose register file with integrated interrupt cause collection for the MIPS-style core. It latches external and internal interrupt events into a sticky pending vector and masks them with SR. On an instruction commit it raises `jisr` and, at that clock edge, saves SR/mode/PC/EA/cause into the exception registers. It also executes return-from-exception (`rfe`) and serves `movg2s`/`movs2g` accesses from the execute stage.

## Interface
Parameters:
- `WIDTH`, 32, datapath width of every SPR.
- `NCAUSE`, 32, number of interrupt cause lines; must be ≤ `WIDTH`.
- `NMASK`, 1, causes `[NMASK-1:0]` are unmaskable; higher causes are gated by `sr[i]`.
- `REPEAT_MASK`, 32'h0000_0000 (`NCAUSE` bits), bit i set means cause i is of *repeat* type, so EPC = `pc`; otherwise EPC = `next_pc`.

Ports (clock/reset: one clock; reset is asynchronous and active-low):
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `ev` in NCAUSE: interrupt event pulses, level-sampled each cycle.
- `commit` in 1: an instruction completes this cycle; interrupts are taken only when high.
- `pc` in WIDTH: PC of the committing instruction.
- `next_pc` in WIDTH: PC of its successor.
- `ea` in WIDTH: effective address of the committing instruction.
- `spr_we` in 1: `movg2s` write strobe.
- `spr_addr` in 3: SPR index (0 SR, 1 ESR, 2 ECA, 3 EPC, 4 EDATA, 5 PTO, 6 PTL, 7 MODE).
- `spr_wdata` in WIDTH: write data.
- `spr_rdata` out WIDTH: combinational read of `spr_addr`.
- `rfe` in 1: return-from-exception commits this cycle.
- `jisr` out 1: interrupt taken this cycle (combinational).
- `il` out 5: index of the highest-priority active cause; valid while `jisr` is high.
- `sr`, `esr`, `eca`, `epc`, `edata`, `pto`, `ptl` out WIDTH: register values.
- `mode` out 1: 0 = system, 1 = user.
- `emode` out 1: saved mode.

## Operation
- `pending[i]` sets on `ev[i]` and holds until its cause is taken.
- `mca = pending & {sr[NCAUSE-1:NMASK], NMASK'b1...}`.
- `jisr = commit & |mca`.
- Priority: the lowest set index in `mca` wins; `il` is that index.
- On the edge where `jisr` is high:
  - `esr<=sr`, `emode<=mode`, `sr<=0`, `mode<=0`.
  - `eca<=mca` (full vector).
  - `epc <= REPEAT_MASK[il] ? pc : next_pc`.
  - `edata<=ea`.
  - `pending <= (pending & ~mca) | ev`: taken causes clear, same-cycle new events stay set.
- On `rfe & commit & ~jisr`: `sr<=esr`, `mode<=emode`. The PC redirect to `epc` is the fetch unit's job.
- On `spr_we & ~jisr`: the addressed register is written. MODE takes `spr_wdata[0]`. A write to MODE while `mode==1` is ignored (privilege). A write to SR while `mode==1` is ignored.
- Reads of unused bits return zero; `spr_rdata` for MODE = `{WIDTH-1'b0, mode}`.

## Timing
- Reset (async, immediate): every output register and `pending` = 0. `mode=0`, `emode=0`, so `jisr=0`.
- Event to `jisr`: 1 cycle. `ev` is registered into `pending`; `jisr` is valid the following cycle if `commit` is high.
- Pending with `commit=0`: held indefinitely and taken at the next commit.
- Precedence on the same edge: `jisr` > `rfe` > `spr_we`. The losing write or restore is dropped.
- `rfe` together with a pending masked-in cause: `jisr` wins. ESR receives the current SR; the restore is discarded.
- Writing SR that unmasks a pending cause: `jisr` can assert on the very next commit cycle.
- Reset asserted mid-handler: all state clears, pending events are lost.

## Configuration
- `SPR_PAGING_EN` defined: PTO/PTL are writable registers; on `jisr` they are left unchanged.
- `SPR_PAGING_EN` undefined: PTO/PTL are tied to 0, reads return 0, writes are ignored.

## Test plan
- Reset then idle: all outputs 0, `jisr=0`. Pulse `ev[0]`; next cycle with `commit=1` gives `jisr=1`, `il=0`. After the edge: `eca=1`, `epc=next_pc`, `sr=0`, `pending=0`.
- Masking: `sr=0`, pulse `ev[5]`, no `jisr`. Write `sr=32'h20`; next commit gives `jisr`, `il=5`, `eca=32'h20`.
- Priority/repeat (`REPEAT_MASK[3]=1`): `sr=FFFF_FFFF`, `ev[3]` and `ev[7]` together, `pc=100h`, `next_pc=104h`. Result: `il=3`, `epc=100h`, `eca=88h`.
- `rfe` restore: in user mode take an interrupt (`esr=sr_old`, `emode=1`), then `rfe` gives `sr=sr_old`, `mode=1`. Repeat with a cause pending: `jisr` wins and `sr` stays 0.
- Same-cycle `spr_we` EDATA=DEAD_BEEF with `jisr` and `ea=1234`: `edata=1234`. Also, a user-mode write to SR leaves SR unchanged.
- Async reset asserted mid-cycle with pending bits set: outputs clear immediately, no `jisr` afterwards. With `SPR_PAGING_EN`, PTO write/readback = 0000_4000; without it, it reads 0.

Source files
------------

// File: rtl/spr_file.sv
// Special-purpose register file with sticky interrupt-cause collection, jisr generation and rfe restore.
// Latency: ev registers into pending (1 cycle to jisr); jisr/il/spr_rdata are combinational; state updates on the edge.
// Backpressure: none; precedence jisr > rfe > spr_we. Optional SPR_PAGING_EN makes PTO/PTL real registers.
module spr_file #(
  parameter int                WIDTH       = 32,
  parameter int                NCAUSE      = 32,
  parameter int                NMASK       = 1,
  parameter logic [NCAUSE-1:0] REPEAT_MASK = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCAUSE-1:0] ev,
  input  logic              commit,
  input  logic [WIDTH-1:0]  pc,
  input  logic [WIDTH-1:0]  next_pc,
  input  logic [WIDTH-1:0]  ea,
  input  logic              spr_we,
  input  logic [2:0]        spr_addr,
  input  logic [WIDTH-1:0]  spr_wdata,
  output logic [WIDTH-1:0]  spr_rdata,
  input  logic              rfe,
  output logic              jisr,
  output logic [4:0]        il,
  output logic [WIDTH-1:0]  sr,
  output logic [WIDTH-1:0]  esr,
  output logic [WIDTH-1:0]  eca,
  output logic [WIDTH-1:0]  epc,
  output logic [WIDTH-1:0]  edata,
  output logic [WIDTH-1:0]  pto,
  output logic [WIDTH-1:0]  ptl,
  output logic              mode,
  output logic              emode
);

  localparam logic [2:0] A_SR    = 3'd0;
  localparam logic [2:0] A_ESR   = 3'd1;
  localparam logic [2:0] A_ECA   = 3'd2;
  localparam logic [2:0] A_EPC   = 3'd3;
  localparam logic [2:0] A_EDATA = 3'd4;
  localparam logic [2:0] A_PTO   = 3'd5;
  localparam logic [2:0] A_PTL   = 3'd6;
  localparam logic [2:0] A_MODE  = 3'd7;

  logic [NCAUSE-1:0] pending;
  logic [NCAUSE-1:0] mask;
  logic [NCAUSE-1:0] mca;
  logic [NCAUSE-1:0] eca_q;
  logic              rfe_take;
  logic              wr;
  logic              priv_ok;

  // Low causes are always enabled; the rest follow the SR enable bits.
  always_comb begin
    mask = '0;
    for (int i = 0; i < NCAUSE; i++) begin
      mask[i] = (i < NMASK) ? 1'b1 : sr[i];
    end
  end

  assign mca  = pending & mask;
  assign jisr = commit & (|mca);

  always_comb begin
    il = '0;
    for (int i = NCAUSE - 1; i >= 0; i--) begin
      if (mca[i]) il = 5'(i);
    end
  end

  assign rfe_take = rfe & commit & ~jisr;
  assign wr       = spr_we & ~jisr;
  assign priv_ok  = ~mode;
  assign eca      = WIDTH'(eca_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else if (jisr) begin
      pending <= (pending & ~mca) | ev;
    end else begin
      pending <= pending | ev;
    end
  end

  // SR and MODE: an rfe restore beats a same-cycle movg2s to them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr   <= '0;
      mode <= 1'b0;
    end else if (jisr) begin
      sr   <= '0;
      mode <= 1'b0;
    end else if (rfe_take) begin
      sr   <= esr;
      mode <= emode;
    end else if (wr && priv_ok) begin
      if (spr_addr == A_SR)   sr   <= spr_wdata;
      if (spr_addr == A_MODE) mode <= spr_wdata[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      esr   <= '0;
      emode <= 1'b0;
      eca_q <= '0;
      epc   <= '0;
      edata <= '0;
    end else if (jisr) begin
      esr   <= sr;
      emode <= mode;
      eca_q <= mca;
      epc   <= REPEAT_MASK[il] ? pc : next_pc;
      edata <= ea;
    end else if (wr) begin
      case (spr_addr)
        A_ESR:   esr   <= spr_wdata;
        A_ECA:   eca_q <= spr_wdata[NCAUSE-1:0];
        A_EPC:   epc   <= spr_wdata;
        A_EDATA: edata <= spr_wdata;
        default: ;
      endcase
    end
  end

`ifdef SPR_PAGING_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pto <= '0;
      ptl <= '0;
    end else if (wr) begin
      if (spr_addr == A_PTO) pto <= spr_wdata;
      if (spr_addr == A_PTL) ptl <= spr_wdata;
    end
  end
`else
  assign pto = '0;
  assign ptl = '0;
`endif

  always_comb begin
    spr_rdata = '0;
    case (spr_addr)
      A_SR:    spr_rdata = sr;
      A_ESR:   spr_rdata = esr;
      A_ECA:   spr_rdata = eca;
      A_EPC:   spr_rdata = epc;
      A_EDATA: spr_rdata = edata;
      A_PTO:   spr_rdata = pto;
      A_PTL:   spr_rdata = ptl;
      A_MODE:  spr_rdata = {{(WIDTH-1){1'b0}}, mode};
      default: spr_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_spr_file.sv
// Bench for spr_file: directed vector table, mid-cycle reset sequence, randomized run against a register-array model.
module tb_spr_file;

  localparam logic [31:0] RPT = 32'h0000_0008;
`ifdef SPR_PAGING_EN
  localparam logic [31:0] PTO_EXP = 32'h0000_4000;
  localparam bit PAGING = 1'b1;
`else
  localparam logic [31:0] PTO_EXP = 32'h0;
  localparam bit PAGING = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ev = '0;
  logic        commit = 1'b0;
  logic [31:0] pc = '0, next_pc = '0, ea = '0;
  logic        spr_we = 1'b0;
  logic [2:0]  spr_addr = '0;
  logic [31:0] spr_wdata = '0;
  logic [31:0] spr_rdata;
  logic        rfe = 1'b0;
  logic        jisr;
  logic [4:0]  il;
  logic [31:0] sr, esr, eca, epc, edata, pto, ptl;
  logic        mode, emode;

  int n_tests = 0;
  int n_fail  = 0;

  spr_file #(.WIDTH(32), .NCAUSE(32), .NMASK(1), .REPEAT_MASK(RPT)) dut (
    .clk(clk), .rst_n(rst_n), .ev(ev), .commit(commit), .pc(pc), .next_pc(next_pc),
    .ea(ea), .spr_we(spr_we), .spr_addr(spr_addr), .spr_wdata(spr_wdata),
    .spr_rdata(spr_rdata), .rfe(rfe), .jisr(jisr), .il(il), .sr(sr), .esr(esr),
    .eca(eca), .epc(epc), .edata(edata), .pto(pto), .ptl(ptl), .mode(mode), .emode(emode)
  );

  always #5 clk = ~clk;

  // Reference model: architectural registers held in an array indexed by SPR number.
  bit [31:0] m_reg [8];
  bit [31:0] m_pend;
  bit        m_emode;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit [31:0] m_mca();
    return m_pend & (m_reg[0] | 32'h1);
  endfunction

  function automatic int lowest(input bit [31:0] v);
    for (int i = 0; i < 32; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
    m_pend  = '0;
    m_emode = 1'b0;
  endtask

  task automatic m_step();
    bit [31:0] mca;
    bit [31:0] nxt [8];
    bit        take;
    bit        user;
    mca  = m_mca();
    take = commit && (mca != 0);
    user = m_reg[7][0];
    nxt  = m_reg;
    if (spr_we) begin
      case (spr_addr)
        3'd0: if (!user) nxt[0] = spr_wdata;
        3'd5, 3'd6: if (PAGING) nxt[spr_addr] = spr_wdata;
        3'd7: if (!user) nxt[7] = {31'b0, spr_wdata[0]};
        default: nxt[spr_addr] = spr_wdata;
      endcase
    end
    if (rfe && commit) begin
      nxt[0] = m_reg[1];
      nxt[7] = {31'b0, m_emode};
    end
    if (take) begin
      nxt    = m_reg;
      nxt[1] = m_reg[0];
      nxt[0] = 0;
      nxt[7] = 0;
      nxt[2] = mca;
      nxt[3] = RPT[lowest(mca)] ? pc : next_pc;
      nxt[4] = ea;
      m_emode = user;
      m_pend  = (m_pend & ~mca) | ev;
    end else begin
      m_pend = m_pend | ev;
    end
    m_reg = nxt;
  endtask

  // Inputs are already applied just after a falling edge.
  task automatic do_cycle(input string nm);
    bit [31:0] mca;
    #1;
    mca = m_mca();
    chk({nm, "_jisr"}, {31'b0, jisr}, {31'b0, commit && (mca != 0)});
    if (commit && (mca != 0)) chk({nm, "_il"}, {27'b0, il}, lowest(mca));
    chk({nm, "_rdata"}, spr_rdata, m_reg[spr_addr]);
    m_step();
    @(posedge clk);
    #1;
    chk({nm, "_sr"}, sr, m_reg[0]);
    chk({nm, "_esr"}, esr, m_reg[1]);
    chk({nm, "_eca"}, eca, m_reg[2]);
    chk({nm, "_epc"}, epc, m_reg[3]);
    chk({nm, "_edata"}, edata, m_reg[4]);
    chk({nm, "_pto"}, pto, m_reg[5]);
    chk({nm, "_ptl"}, ptl, m_reg[6]);
    chk({nm, "_mode"}, {31'b0, mode}, m_reg[7]);
    chk({nm, "_emode"}, {31'b0, emode}, {31'b0, m_emode});
    @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] ev;
    logic        commit;
    logic [31:0] pc, npc, ea;
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wd;
    logic        rfe;
    logic        ejisr;
    logic [4:0]  eil;
    logic [31:0] erd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic [31:0] e, input logic c, input logic [31:0] p,
                             input logic [31:0] n, input logic [31:0] a, input logic w,
                             input logic [2:0] ad, input logic [31:0] wd, input logic r,
                             input logic ej, input logic [4:0] ei, input logic [31:0] er);
    vec_t t;
    t.ev = e; t.commit = c; t.pc = p; t.npc = n; t.ea = a; t.we = w; t.addr = ad;
    t.wd = wd; t.rfe = r; t.ejisr = ej; t.eil = ei; t.erd = er;
    return t;
  endfunction

  initial begin
    //            ev     cm pc      npc     ea      we ad wdata         rfe jisr il rdata
    tbl.push_back(v(0,    0, 0,      0,      0,      0, 0, 0,            0, 0, 0, 0));
    tbl.push_back(v(1,    0, 0,      0,      0,      0, 0, 0,            0, 0, 0, 0));
    tbl.push_back(v(0,    1, 32'h10, 32'h14, 32'h55, 0, 2, 0,            0, 1, 0, 0));
    tbl.push_back(v(0,    0, 0,      0,      0,      0, 2, 0,            0, 0, 0, 32'h1));
    tbl.push_back(v(0,    0, 0,      0,      0,      0, 3, 0,            0, 0, 0, 32'h14));
    tbl.push_back(v(0,    0, 0,      0,      0,      0, 4, 0,            0, 0, 0, 32'h55));
    tbl.push_back(v(32'h20, 1, 0,    0,      0,      0, 0, 0,            0, 0, 0, 0));
    tbl.push_back(v(0,    1, 0,      0,      0,      0, 0, 0,            0, 0, 0, 0));
    tbl.push_back(v(0,    0, 0,      0,      0,      1, 0, 32'h20,       0, 0, 0, 0));
    tbl.push_back(v(0,    1, 32'h20, 32'h24, 0,      0, 0, 0,            0, 1, 5, 32'h20));
    tbl.push_back(v(0,    0, 0,      0,      0,      0, 2, 0,            0, 0, 0, 32'h20));
    tbl.push_back(v(0,    0, 0,      0,      0,      0, 1, 0,            0, 0, 0, 32'h20));
    tbl.push_back(v(0,    0, 0,      0,      0,      1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0));
    tbl.push_back(v(32'h88, 0, 0,    0,      0,      0, 0, 0,            0, 0, 0, 32'hFFFF_FFFF));
    tbl.push_back(v(0,    1, 32'h100, 32'h104, 0,    0, 3, 0,            0, 1, 3, 32'h24));
    tbl.push_back(v(0,    0, 0,      0,      0,      0, 3, 0,            0, 0, 0, 32'h100));
    tbl.push_back(v(0,    0, 0,      0,      0,      0, 2, 0,            0, 0, 0, 32'h88));
    tbl.push_back(v(1,    0, 0,      0,      0,      0, 1, 0,            0, 0, 0, 32'hFFFF_FFFF));
    tbl.push_back(v(0,    1, 0,      0,      32'h1234, 1, 4, 32'hDEAD_BEEF, 0, 1, 0, 0));
    tbl.push_back(v(0,    0, 0,      0,      0,      0, 4, 0,            0, 0, 0, 32'h1234));
    tbl.push_back(v(0,    0, 0,      0,      0,      1, 0, 32'hF0,       0, 0, 0, 0));
    tbl.push_back(v(0,    0, 0,      0,      0,      1, 7, 32'h1,        0, 0, 0, 0));
    tbl.push_back(v(0,    0, 0,      0,      0,      0, 7, 0,            0, 0, 0, 32'h1));
    tbl.push_back(v(0,    0, 0,      0,      0,      1, 0, 32'h0,        0, 0, 0, 32'hF0));
    tbl.push_back(v(1,    0, 0,      0,      0,      0, 0, 0,            0, 0, 0, 32'hF0));
    tbl.push_back(v(0,    1, 0,      0,      0,      0, 1, 0,            0, 1, 0, 0));
    tbl.push_back(v(0,    0, 0,      0,      0,      0, 1, 0,            0, 0, 0, 32'hF0));
    tbl.push_back(v(0,    0, 0,      0,      0,      0, 7, 0,            0, 0, 0, 0));
    tbl.push_back(v(0,    1, 0,      0,      0,      0, 0, 0,            1, 0, 0, 0));
    tbl.push_back(v(0,    0, 0,      0,      0,      0, 0, 0,            0, 0, 0, 32'hF0));
    tbl.push_back(v(0,    0, 0,      0,      0,      0, 7, 0,            0, 0, 0, 32'h1));
    tbl.push_back(v(1,    0, 0,      0,      0,      0, 0, 0,            0, 0, 0, 32'hF0));
    tbl.push_back(v(0,    1, 0,      0,      0,      0, 0, 0,            1, 1, 0, 32'hF0));
    tbl.push_back(v(0,    0, 0,      0,      0,      0, 0, 0,            0, 0, 0, 0));
    tbl.push_back(v(0,    0, 0,      0,      0,      0, 7, 0,            0, 0, 0, 0));
    tbl.push_back(v(0,    0, 0,      0,      0,      1, 5, 32'h4000,     0, 0, 0, 0));
    tbl.push_back(v(0,    0, 0,      0,      0,      0, 5, 0,            0, 0, 0, PTO_EXP));

    // Reset state
    m_reset();
    #1;
    chk("rst_sr", sr, 0);
    chk("rst_esr", esr, 0);
    chk("rst_eca", eca, 0);
    chk("rst_epc", epc, 0);
    chk("rst_edata", edata, 0);
    chk("rst_mode", {31'b0, mode}, 0);
    chk("rst_emode", {31'b0, emode}, 0);
    chk("rst_jisr", {31'b0, jisr}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vector table
    for (int k = 0; k < tbl.size(); k++) begin
      ev = tbl[k].ev; commit = tbl[k].commit; pc = tbl[k].pc; next_pc = tbl[k].npc;
      ea = tbl[k].ea; spr_we = tbl[k].we; spr_addr = tbl[k].addr;
      spr_wdata = tbl[k].wd; rfe = tbl[k].rfe;
      #1;
      chk($sformatf("vec%0d_jisr", k), {31'b0, jisr}, {31'b0, tbl[k].ejisr});
      if (tbl[k].ejisr) chk($sformatf("vec%0d_il", k), {27'b0, il}, {27'b0, tbl[k].eil});
      chk($sformatf("vec%0d_rd", k), spr_rdata, tbl[k].erd);
      do_cycle($sformatf("vec%0d", k));
    end

    // Asynchronous reset in the middle of a cycle with a masked-in cause pending
    ev = 0; commit = 0; rfe = 0; spr_we = 1; spr_addr = 0; spr_wdata = 32'hFFFF_FFFF;
    do_cycle("ar_wsr");
    spr_we = 0; ev = 32'h10;
    do_cycle("ar_ev");
    ev = 0; commit = 1;
    #2;
    chk("ar_pre_jisr", {31'b0, jisr}, 1);
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("ar_sr", sr, 0);
    chk("ar_mode", {31'b0, mode}, 0);
    chk("ar_jisr", {31'b0, jisr}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("ar_post_jisr", {31'b0, jisr}, 0);
      do_cycle("ar_post");
    end

    // Randomized run against the model
    for (int k = 0; k < 600; k++) begin
      ev        = ($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
      commit    = $urandom_range(0, 1);
      pc        = $urandom & 32'hFFFF_FFFC;
      next_pc   = pc + 4;
      ea        = $urandom;
      spr_we    = ($urandom_range(0, 2) == 0);
      spr_addr  = 3'($urandom_range(0, 7));
      spr_wdata = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 255));
      rfe       = ($urandom_range(0, 5) == 0);
      do_cycle("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
